// File: rtl/sa_loadable_weights_if.sv
// Handshake and data bundle for the loadable-weight systolic array.
// The master side offers weight rows and activation vectors; the slave
// side (the array) reports readiness and presents last-row partial sums.
interface sa_loadable_weights_if #(
    parameter int SA_SIZE         = 8,
    parameter int WEIGHT_SIZE     = 8,
    parameter int ACTIVATION_SIZE = 8,
    parameter int ACC_SIZE        = 16
);
    logic                       w_valid;
    logic                       w_ready;
    logic [WEIGHT_SIZE-1:0]     w_data  [SA_SIZE];
    logic                       in_valid;
    logic                       in_ready;
    logic [ACTIVATION_SIZE-1:0] inputs  [SA_SIZE];
    logic                       out_valid;
    logic [ACC_SIZE-1:0]        outputs [SA_SIZE];

    modport master (
        output w_valid, w_data, in_valid, inputs,
        input  w_ready, in_ready, out_valid, outputs
    );

    modport slave (
        input  w_valid, w_data, in_valid, inputs,
        output w_ready, in_ready, out_valid, outputs
    );
endinterface

// File: rtl/sa_loadable_weights.sv
// Weight-stationary SA_SIZE x SA_SIZE systolic array with a row-by-row
// weight loader. Activations flow right, partial sums flow down, and the
// last-row PE results are presented combinationally on every advance.
// A weight beat arriving while ACTIVE starts a reload and flushes the
// pipeline so stale partial sums never mix with the new weights.
module sa_loadable_weights #(
    parameter int SA_SIZE         = 8,
    parameter int WEIGHT_SIZE     = 8,
    parameter int ACTIVATION_SIZE = 8,
    parameter int ACC_SIZE        = 16
) (
    input logic                  clk,
    input logic                  resetn,
    sa_loadable_weights_if.slave bus
);

    localparam int RW = $clog2(SA_SIZE);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rowCnt_q, rowCnt_d;

    logic [WEIGHT_SIZE-1:0]     weight_q [SA_SIZE][SA_SIZE];
    logic [ACTIVATION_SIZE-1:0] act_q    [SA_SIZE][SA_SIZE-1];
    logic [ACC_SIZE-1:0]        psum_q   [SA_SIZE-1][SA_SIZE];

    logic [ACTIVATION_SIZE-1:0] actIn    [SA_SIZE][SA_SIZE];
    logic [ACC_SIZE-1:0]        accIn    [SA_SIZE][SA_SIZE];
    logic [ACC_SIZE-1:0]        peOut    [SA_SIZE][SA_SIZE];

    logic            wFire;
    logic            inReady;
    logic            advance;
    logic            clearPipe;
    logic [RW-1:0]   writeRow;

    // The array always accepts weight beats; a beat wins over activations.
    assign wFire     = bus.w_valid;
    assign inReady   = (state_q == ACTIVE) && !bus.w_valid;
    assign advance   = bus.in_valid && inReady;
    assign clearPipe = wFire && (state_q == ACTIVE);
    assign writeRow  = (state_q == ACTIVE) ? '0 : rowCnt_q;

    assign bus.w_ready   = 1'b1;
    assign bus.in_ready  = inReady;
    assign bus.out_valid = advance;

    // PE grid: each cell adds its weighted activation to the sum from above.
    for (genvar r = 0; r < SA_SIZE; r++) begin : gRow
        for (genvar c = 0; c < SA_SIZE; c++) begin : gCol
            if (c == 0) begin : gActEdge
                assign actIn[r][c] = bus.inputs[r];
            end else begin : gActInner
                assign actIn[r][c] = act_q[r][c-1];
            end
            if (r == 0) begin : gAccEdge
                assign accIn[r][c] = '0;
            end else begin : gAccInner
                assign accIn[r][c] = psum_q[r-1][c];
            end
            assign peOut[r][c] = accIn[r][c]
                               + ACC_SIZE'(actIn[r][c]) * ACC_SIZE'(weight_q[r][c]);
        end
    end

    // Last-row results leave the array with no register stage.
    for (genvar c = 0; c < SA_SIZE; c++) begin : gOut
        assign bus.outputs[c] = peOut[SA_SIZE-1][c];
    end

    // State and row counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= EMPTY;
            rowCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rowCnt_q <= rowCnt_d;
        end
    end

    // Loader sequencing: count weight rows and decide when the array is live.
    always_comb begin
        state_d  = state_q;
        rowCnt_d = rowCnt_q;
        unique case (state_q)
            EMPTY: begin
                if (wFire) begin
                    state_d  = LOAD;
                    rowCnt_d = rowCnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (wFire) begin
                    if (rowCnt_q == RW'(SA_SIZE - 1)) begin
                        state_d  = ACTIVE;
                        rowCnt_d = '0;
                    end else begin
                        rowCnt_d = rowCnt_q + 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (wFire) begin
                    state_d  = LOAD;
                    rowCnt_d = RW'(1);
                end
            end
            default: begin
                state_d  = EMPTY;
                rowCnt_d = '0;
            end
        endcase
    end

    // Weight storage: one full row is captured per fired beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < SA_SIZE; r++) begin
                for (int c = 0; c < SA_SIZE; c++) begin
                    weight_q[r][c] <= '0;
                end
            end
        end else if (wFire) begin
            for (int r = 0; r < SA_SIZE; r++) begin
                if (writeRow == RW'(r)) begin
                    for (int c = 0; c < SA_SIZE; c++) begin
                        weight_q[r][c] <= bus.w_data[c];
                    end
                end
            end
        end
    end

    // Activation pipeline: shifts right on advance, holds on stall, flushes on reload.
    always_ff @(posedge clk) begin
        if (!resetn || clearPipe) begin
            for (int r = 0; r < SA_SIZE; r++) begin
                for (int c = 0; c < SA_SIZE - 1; c++) begin
                    act_q[r][c] <= '0;
                end
            end
        end else if (advance) begin
            for (int r = 0; r < SA_SIZE; r++) begin
                for (int c = 0; c < SA_SIZE - 1; c++) begin
                    act_q[r][c] <= actIn[r][c];
                end
            end
        end
    end

    // Partial-sum pipeline: moves down on advance, holds on stall, flushes on reload.
    always_ff @(posedge clk) begin
        if (!resetn || clearPipe) begin
            for (int r = 0; r < SA_SIZE - 1; r++) begin
                for (int c = 0; c < SA_SIZE; c++) begin
                    psum_q[r][c] <= '0;
                end
            end
        end else if (advance) begin
            for (int r = 0; r < SA_SIZE - 1; r++) begin
                for (int c = 0; c < SA_SIZE; c++) begin
                    psum_q[r][c] <= peOut[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_loadable_weights.sv
// Directed bench for the 2x2 loadable-weight array: load, compute, stall,
// reload contention, reset mid-load, plus an 8-bit accumulator wrap case.
module tb_sa_loadable_weights;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    sa_loadable_weights_if #(.SA_SIZE(2), .WEIGHT_SIZE(8), .ACTIVATION_SIZE(8), .ACC_SIZE(16)) bus16 ();
    sa_loadable_weights_if #(.SA_SIZE(2), .WEIGHT_SIZE(8), .ACTIVATION_SIZE(8), .ACC_SIZE(8))  bus8 ();

    sa_loadable_weights #(.SA_SIZE(2), .WEIGHT_SIZE(8), .ACTIVATION_SIZE(8), .ACC_SIZE(16)) dut16 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus16.slave)
    );

    sa_loadable_weights #(.SA_SIZE(2), .WEIGHT_SIZE(8), .ACTIVATION_SIZE(8), .ACC_SIZE(8)) dut8 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus8.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle on the 16-bit array at the falling edge, then waits a
    // little so combinational outputs can be sampled before the rising edge.
    task automatic applyStimulus(input logic wv, input logic [7:0] w0, input logic [7:0] w1,
                                 input logic iv, input logic [7:0] a0, input logic [7:0] a1);
        @(negedge clk);
        bus16.w_valid   = wv;
        bus16.w_data[0] = w0;
        bus16.w_data[1] = w1;
        bus16.in_valid  = iv;
        bus16.inputs[0] = a0;
        bus16.inputs[1] = a1;
        #2;
    endtask

    task automatic apply8(input logic wv, input logic [7:0] w0, input logic [7:0] w1,
                          input logic iv, input logic [7:0] a0, input logic [7:0] a1);
        @(negedge clk);
        bus8.w_valid   = wv;
        bus8.w_data[0] = w0;
        bus8.w_data[1] = w1;
        bus8.in_valid  = iv;
        bus8.inputs[0] = a0;
        bus8.inputs[1] = a1;
        #2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        bus16.w_valid = 1'b0; bus16.in_valid = 1'b0;
        bus16.w_data[0] = '0; bus16.w_data[1] = '0;
        bus16.inputs[0] = '0; bus16.inputs[1] = '0;
        bus8.w_valid = 1'b0; bus8.in_valid = 1'b0;
        bus8.w_data[0] = '0; bus8.w_data[1] = '0;
        bus8.inputs[0] = '0; bus8.inputs[1] = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_w_ready",   32'(bus16.w_ready),    1);
        checkOutput("rst_in_ready",  32'(bus16.in_ready),   0);
        checkOutput("rst_out_valid", 32'(bus16.out_valid),  0);
        checkOutput("rst_out0",      32'(bus16.outputs[0]), 0);
        checkOutput("rst_out1",      32'(bus16.outputs[1]), 0);
        checkOutput("rst_state",     32'(dut16.state_q),    0);
        resetn = 1'b1;

        // Activations offered while EMPTY are ignored.
        applyStimulus(0, 0, 0, 1, 7, 7);
        checkOutput("empty_in_ready",  32'(bus16.in_ready),  0);
        checkOutput("empty_out_valid", 32'(bus16.out_valid), 0);
        applyStimulus(1, 1, 2, 0, 0, 0);
        checkOutput("empty_stays", 32'(dut16.state_q), 0);
        applyStimulus(1, 3, 4, 1, 7, 7);
        checkOutput("load_state",     32'(dut16.state_q),    1);
        checkOutput("load_in_ready",  32'(bus16.in_ready),   0);
        checkOutput("load_out_valid", 32'(bus16.out_valid),  0);

        // Basic compute: 23 on outputs[0] at advance 2, 34 on outputs[1] at advance 3.
        applyStimulus(0, 0, 0, 1, 5, 0);
        checkOutput("active_state",  32'(dut16.state_q),   2);
        checkOutput("adv1_in_ready", 32'(bus16.in_ready),  1);
        checkOutput("adv1_valid",    32'(bus16.out_valid), 1);
        applyStimulus(0, 0, 0, 1, 0, 6);
        checkOutput("adv2_out0", 32'(bus16.outputs[0]), 23);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("adv3_out1", 32'(bus16.outputs[1]), 34);

        // Reload the same weights (flushes the pipeline), then repeat with stalls.
        applyStimulus(1, 1, 2, 0, 0, 0);
        applyStimulus(1, 3, 4, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5, 0);
        checkOutput("stall_adv1_valid", 32'(bus16.out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 9, 9);
            checkOutput("stall_a_valid", 32'(bus16.out_valid), 0);
        end
        applyStimulus(0, 0, 0, 1, 0, 6);
        checkOutput("stall_adv2_out0", 32'(bus16.outputs[0]), 23);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 9, 9);
            checkOutput("stall_b_valid", 32'(bus16.out_valid), 0);
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("stall_adv3_out1", 32'(bus16.outputs[1]), 34);

        // Contention: weight beat beats the activation and flushes the pipeline.
        applyStimulus(0, 0, 0, 1, 5, 6);
        applyStimulus(1, 1, 2, 1, 9, 9);
        checkOutput("cont_in_ready",  32'(bus16.in_ready),  0);
        checkOutput("cont_out_valid", 32'(bus16.out_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("cont_state", 32'(dut16.state_q),      1);
        checkOutput("cont_psum",  32'(dut16.psum_q[0][0]), 0);
        checkOutput("cont_act",   32'(dut16.act_q[0][0]),  0);
        checkOutput("cont_act1",  32'(dut16.act_q[1][0]),  0);
        applyStimulus(1, 3, 4, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("reload_active", 32'(dut16.state_q), 2);

        // Reset in the middle of a load.
        applyStimulus(1, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        checkOutput("mid_rst_state",    32'(dut16.state_q),        0);
        checkOutput("mid_rst_weight",   32'(dut16.weight_q[0][0]), 0);
        checkOutput("mid_rst_in_ready", 32'(bus16.in_ready),       0);
        applyStimulus(1, 1, 2, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("half_load_in_ready", 32'(bus16.in_ready), 0);
        applyStimulus(1, 3, 4, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("full_load_in_ready", 32'(bus16.in_ready), 1);

        // Accumulator wrap on the 8-bit instance: 255*255 mod 256 = 1.
        apply8(1, 255, 0, 0, 0, 0);
        apply8(1, 0, 0, 0, 0, 0);
        apply8(0, 0, 0, 1, 255, 0);
        checkOutput("wrap_adv1_valid", 32'(bus8.out_valid), 1);
        apply8(0, 0, 0, 1, 0, 0);
        checkOutput("wrap_out0", 32'(bus8.outputs[0]), 1);
        apply8(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #50000;
        $display("[TB] FAIL timeout actual=%0d expected=%0d", 0, 1);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/sa_loadable_weights.md
SA_LOADABLE_WEIGHTS -- requirements
Module: sa_loadable_weights

Interface
REQ-001 SHALL have parameter SA_SIZE, default 8: array rows and columns; legal range 2 or more.
REQ-002 SHALL have parameter WEIGHT_SIZE, default 8: unsigned weight width.
REQ-003 SHALL have parameter ACTIVATION_SIZE, default 8: unsigned activation width.
REQ-004 SHALL have parameter ACC_SIZE, default 16: unsigned partial-sum and output width.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on posedge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port w_valid, input, 1 bit: a weight row beat is offered.
REQ-008 SHALL have port w_ready, output, 1 bit: the block can accept a weight beat.
REQ-009 SHALL have port w_data[SA_SIZE], input, WEIGHT_SIZE each: one weight row; element c targets column c.
REQ-010 SHALL have port in_valid, input, 1 bit: an activation vector is offered.
REQ-011 SHALL have port in_ready, output, 1 bit: the block can accept an activation vector.
REQ-012 SHALL have port inputs[SA_SIZE], input, ACTIVATION_SIZE each: element r feeds row r, column 0.
REQ-013 SHALL have port out_valid, output, 1 bit: outputs are meaningful this cycle.
REQ-014 SHALL have port outputs[SA_SIZE], output, ACC_SIZE each: last-row partial sums.

Function
REQ-015 SHALL implement an SA_SIZE x SA_SIZE weight-stationary grid.
- Activations move right one column per advance.
- Partial sums move down one row per advance.
- Row 0 partial-sum input is 0.
REQ-016 Each PE SHALL compute out = acc + in*w, unsigned, truncated modulo 2^ACC_SIZE.
REQ-017 The FSM SHALL have exactly three states: EMPTY, LOAD, ACTIVE.
REQ-018 The weight handshake SHALL fire when w_valid && w_ready; w_ready SHALL be 1 in every state.
REQ-019 Row counter and EMPTY transition: a fired weight beat SHALL write w_data into weights[row_cnt][*] and increment row_cnt. In EMPTY, it SHALL move the FSM to LOAD.
REQ-020 LOAD completion: the beat with row_cnt == SA_SIZE-1 SHALL move the FSM to ACTIVE and wrap row_cnt to 0.
REQ-021 SA_SIZE==2 case: the FSM SHALL still pass through LOAD for exactly one cycle.
REQ-022 A weight beat fired in ACTIVE SHALL start a reload:
- the beat is written to row 0 and the FSM moves to LOAD;
- all pipeline registers (activation and partial-sum) clear to 0 on the same edge.
REQ-023 in_ready SHALL equal (state==ACTIVE) && !w_valid; when both valids are high in ACTIVE, the weight beat wins and no input is accepted.
REQ-024 advance SHALL equal in_valid && in_ready.
- On advance, every pipeline register loads its PE result.
- Without advance, every pipeline register holds its value (stall).
REQ-025 Output timing: outputs SHALL be combinational from the last-row PEs, with zero latency from the advancing input vector. out_valid SHALL equal advance.
REQ-026 Input skew: the block SHALL apply no input skewing. Row r data for a given column result must be presented r cycles after row 0, with column c results emerging c advances later.
REQ-027 Mid-load stimulus: in_valid during EMPTY or LOAD SHALL be ignored with no state change; row_cnt SHALL NOT advance without a fired weight beat.

Reset
REQ-028 When resetn=0 at a posedge, all of the following SHALL be set:
- state=EMPTY, row_cnt=0;
- all weights, activation registers and partial-sum registers = 0.
REQ-029 Output values in reset and EMPTY: during and after reset, w_ready=1, in_ready=0, out_valid=0 and outputs=0.
REQ-030 Reset SHALL override any concurrent handshake, including reset asserted mid-LOAD or mid-computation.

Verification
REQ-031 Load and compute (SA_SIZE=2, ACC_SIZE=16):
- load beats {1,2} then {3,4};
- advance {5,0}, then {0,6}, then {0,0};
- required: outputs[0]=23 on the 2nd advance; outputs[1]=34 on the 3rd advance.
REQ-032 Stall: repeat REQ-031 with in_valid=0 for 3 cycles between advances -> out_valid=0 while stalled; identical values on the advancing cycles.
REQ-033 Wrap (ACC_SIZE=8): weights {255,0},{0,0}; advance {255,0}, then {0,0} -> outputs[0]=1 on the 2nd advance.
REQ-034 Contention: in ACTIVE, drive w_valid and in_valid together -> in_ready=0, out_valid=0, FSM=LOAD next cycle, pipeline registers read 0.
REQ-035 Reset mid-LOAD: after 1 of 2 beats, pulse resetn=0 -> state EMPTY, weights 0, in_ready=0; a fresh 2-beat load is then required before in_ready=1.
